tu_demux_rx: RTL and testbench

Parametrised receive-side TU demultiplexer. It takes the byte-interleaved tributary stream delivered by the TUG-3/VC-4 de-mapper and distributes it round-robin into NCH per-channel elastic buffers. Each buffer is drained independently by that channel's egress/desynchroniser logic. The block adds three things over the fixed 21-channel receiver: configurable channel count and buffer depth, per-channel enable masking, and overflow/underflow/alignment status.

---
 rtl/tu_rx_pkg.sv | 21 ++
 rtl/tu_chan_fifo.sv | 82 ++++++++
 rtl/tu_demux_rx.sv | 99 +++++++++
 tb/tb_tu_demux_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tu_rx_pkg.sv
// Shared constants, types and helpers for the TU receive demultiplexer.
package tu_rx_pkg;

  localparam int unsigned NCH_TUG3 = 21;  // TU-12s in a TUG-3
  localparam int unsigned NCH_VC4  = 63;  // TU-12s in a VC-4
  localparam int unsigned BYTE_W   = 8;

  // One channel's slice of the packed read-data bus.
  typedef logic [BYTE_W-1:0] tu_byte_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tu_chan_fifo.sv
// Single-channel elastic buffer with sticky overflow/underflow flags.
module tu_chan_fifo
  import tu_rx_pkg::*;
#(
  parameter int unsigned WIDTH = BYTE_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvld,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             rvld_q, ovf_q, unf_q;
  logic             do_push, do_pop, ovf_set, unf_set;

  // Status decode and push/pop qualification; a pop never sees a same-cycle push.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop & ~flush & ~empty;
    do_push = push & ~flush & (~full | do_pop);
    ovf_set = push & ~flush & full & ~do_pop;
    unf_set = pop & ~flush & empty;
  end

  // Pointers; a disabled channel is held flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care while pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  // Read data register, pop strobe and sticky flags (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rvld_q <= do_pop;
      if (do_pop) rdata_q <= mem_q[rptr_q[AW-1:0]];
      if (ovf_set)  ovf_q <= 1'b1;
      else if (clr) ovf_q <= 1'b0;
      if (unf_set)  unf_q <= 1'b1;
      else if (clr) unf_q <= 1'b0;
    end
  end

  assign rdata = rdata_q;
  assign rvld  = rvld_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: rtl/tu_demux_rx.sv
// Receive-side TU demultiplexer: round-robin byte distribution into NCH buffers.
module tu_demux_rx
  import tu_rx_pkg::*;
#(
  parameter int unsigned WIDTH = BYTE_W,
  parameter int unsigned NCH   = NCH_TUG3,
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxsof,
  input  logic [WIDTH-1:0]     datain,
  input  logic                 din_vld,
  input  logic [NCH-1:0]       chan_en,
  input  logic [NCH-1:0]       rd_en,
  input  logic [NCH-1:0]       clr_stat,
  output logic [NCH*WIDTH-1:0] dout,
  output logic [NCH-1:0]       dout_vld,
  output logic [NCH-1:0]       empty,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       unf,
  output logic                 align_err
);

  localparam int unsigned    CW      = clog2(NCH);
  localparam logic [CW-1:0]  LAST_CH = CW'(NCH - 1);

  logic [CW-1:0]    ch_cnt_q, ch_cnt_d, cur_ch;
  logic [CW-1:0]    in_ch_q;
  logic [WIDTH-1:0] in_data_q;
  logic             in_vld_q;
  logic             sof_seen_q, align_q, align_d;
  logic [NCH-1:0]   push;

  // Channel for the current byte and next counter value; rxsof forces channel 0.
  always_comb begin
    cur_ch   = rxsof ? '0 : ch_cnt_q;
    ch_cnt_d = ch_cnt_q;
    if (rxsof) begin
      ch_cnt_d = din_vld ? CW'(1) : '0;
    end else if (din_vld) begin
      ch_cnt_d = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + 1'b1;
    end
    // The very first rxsof only establishes alignment.
    align_d = rxsof & sof_seen_q & (ch_cnt_q != '0);
  end

  // Channel counter, input stage and alignment pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt_q   <= '0;
      in_ch_q    <= '0;
      in_data_q  <= '0;
      in_vld_q   <= 1'b0;
      sof_seen_q <= 1'b0;
      align_q    <= 1'b0;
    end else begin
      ch_cnt_q  <= ch_cnt_d;
      in_ch_q   <= cur_ch;
      in_data_q <= datain;
      in_vld_q  <= din_vld;
      align_q   <= align_d;
      if (rxsof) sof_seen_q <= 1'b1;
    end
  end

  assign align_err = align_q;

  // One-hot write select from the registered input stage.
  always_comb begin
    push = '0;
    for (int c = 0; c < NCH; c++) begin
      push[c] = in_vld_q && (in_ch_q == CW'(c));
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    tu_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .wdata (in_data_q),
      .pop   (rd_en[c]),
      .flush (~chan_en[c]),
      .clr   (clr_stat[c]),
      .rdata (dout[c*WIDTH +: WIDTH]),
      .rvld  (dout_vld[c]),
      .empty (empty[c]),
      .full  (full[c]),
      .ovf   (ovf[c]),
      .unf   (unf[c])
    );
  end

endmodule

// File: tb/tb_tu_demux_rx.sv
// Randomised bench for tu_demux_rx with a queue-based reference model.
module tb_tu_demux_rx;
  import tu_rx_pkg::*;

  localparam int NCH   = 21;
  localparam int DEPTH = 8;
  localparam int W     = 8;
  localparam int NCH2  = 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: NCH=21, DEPTH=8
  logic             rst, sof, vld;
  logic [W-1:0]     din;
  logic [NCH-1:0]   en, rd, clr;
  logic [NCH*W-1:0] dout;
  logic [NCH-1:0]   dv, emp, ful, ovf, unf;
  logic             ae;

  tu_demux_rx #(.WIDTH(W), .NCH(NCH), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .rxsof(sof), .datain(din), .din_vld(vld), .chan_en(en),
    .rd_en(rd), .clr_stat(clr), .dout(dout), .dout_vld(dv), .empty(emp), .full(ful),
    .ovf(ovf), .unf(unf), .align_err(ae)
  );

  // Second DUT: NCH=63, DEPTH=4
  logic              rst2, sof2, vld2;
  logic [W-1:0]      din2;
  logic [NCH2-1:0]   en2, rd2, clr2;
  logic [NCH2*W-1:0] dout2;
  logic [NCH2-1:0]   dv2, emp2, ful2, ovf2, unf2;
  logic              ae2;

  tu_demux_rx #(.WIDTH(W), .NCH(NCH2), .DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst2), .rxsof(sof2), .datain(din2), .din_vld(vld2), .chan_en(en2),
    .rd_en(rd2), .clr_stat(clr2), .dout(dout2), .dout_vld(dv2), .empty(emp2), .full(ful2),
    .ovf(ovf2), .unf(unf2), .align_err(ae2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  tu_byte_t         mq [NCH][$];
  bit               m_ovf [NCH];
  bit               m_unf [NCH];
  logic [NCH*W-1:0] m_dout;
  logic [NCH-1:0]   m_vld;
  bit               m_align, m_seen;
  int               m_cnt;
  bit               p_vld;
  int               p_ch;
  tu_byte_t         p_data;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_ovf[c] = 0;
      m_unf[c] = 0;
    end
    m_dout = '0; m_vld = '0; m_align = 0; m_seen = 0; m_cnt = 0;
    p_vld = 0; p_ch = 0; p_data = '0;
  endtask

  // Apply one clock edge of behaviour using the current inputs.
  task automatic model_edge();
    int ch;
    for (int c = 0; c < NCH; c++) begin
      int sz;
      bit popped, o_set, u_set;
      sz = mq[c].size();
      popped = 0; o_set = 0; u_set = 0;
      m_vld[c] = 1'b0;
      if (!en[c]) begin
        mq[c].delete();
      end else begin
        if (rd[c]) begin
          if (sz > 0) begin
            m_dout[c*W +: W] = mq[c].pop_front();
            m_vld[c] = 1'b1;
            popped = 1;
          end else begin
            u_set = 1;
          end
        end
        if (p_vld && p_ch == c) begin
          if (sz == DEPTH && !popped) o_set = 1;
          else mq[c].push_back(p_data);
        end
      end
      if (o_set) m_ovf[c] = 1; else if (clr[c]) m_ovf[c] = 0;
      if (u_set) m_unf[c] = 1; else if (clr[c]) m_unf[c] = 0;
    end
    m_align = sof && m_seen && (m_cnt != 0);
    if (sof) m_seen = 1;
    ch = sof ? 0 : m_cnt;
    p_vld = vld; p_ch = ch; p_data = din;
    if (vld) m_cnt = (ch + 1) % NCH;
    else if (sof) m_cnt = 0;
  endtask

  task automatic compare();
    logic [NCH-1:0] e_emp, e_ful, e_ovf, e_unf;
    for (int c = 0; c < NCH; c++) begin
      e_emp[c] = (mq[c].size() == 0);
      e_ful[c] = (mq[c].size() == DEPTH);
      e_ovf[c] = m_ovf[c];
      e_unf[c] = m_unf[c];
    end
    chk("dout_vld", dv, m_vld);
    chk("dout", dout, m_dout);
    chk("empty", emp, e_emp);
    chk("full", ful, e_ful);
    chk("ovf", ovf, e_ovf);
    chk("unf", unf, e_unf);
    chk("align_err", ae, m_align);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic step2();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NCH2-1:0] ones2;
    rst = 1'b1; sof = 0; vld = 0; din = '0; en = '1; rd = '0; clr = '0;
    rst2 = 1'b1; sof2 = 0; vld2 = 0; din2 = '0; en2 = '1; rd2 = '0; clr2 = '0;
    ones2 = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst2 = 1'b0;
    model_reset();
    compare();

    // Three aligned rows of bytes 0..62, then drain everything.
    for (int b = 0; b < 3 * NCH; b++) begin
      sof = (b == 0); vld = 1; din = W'(b);
      step();
    end
    sof = 0; vld = 0;
    step(); step();
    rd = '1;
    repeat (4) step();
    rd = '0; clr = '1;
    step();
    clr = '0;

    // Channel 5 starved of reads for nine rows.
    for (int r = 0; r < 9; r++) begin
      for (int b = 0; b < NCH; b++) begin
        sof = (r == 0 && b == 0); vld = 1; din = W'($urandom);
        rd = ~(NCH'(1) << 5);
        step();
      end
    end
    sof = 0; vld = 0;
    step(); step();
    chk("full5", ful[5], 1);
    chk("ovf5", ovf[5], 1);
    chk("ovf_others", ovf & ~(NCH'(1) << 5), 0);
    rd = '0; clr = NCH'(1) << 5;
    step();
    clr = '0;
    chk("ovf5_clr", ovf[5], 0);

    // Random traffic with rxsof slips, channel 7 disable window, mid-run reset.
    for (int i = 0; i < 1600; i++) begin
      vld = ($urandom % 4) != 0;
      din = W'($urandom);
      sof = ($urandom % 40) == 0;
      if (((i / 200) % 2) == 0) rd = NCH'($urandom & $urandom);
      else rd = NCH'($urandom & $urandom & $urandom & $urandom & $urandom & $urandom);
      clr = (($urandom % 16) == 0) ? NCH'($urandom) : '0;
      en = '1;
      if (i >= 300 && i < 600) en[7] = 1'b0;
      if (i == 800) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        #1 rst = 1'b0;
      end
      step();
    end
    vld = 0; sof = 0; rd = '0; clr = '0;
    step();

    // Wide configuration: one row, read back the last channel.
    for (int b = 0; b < NCH2; b++) begin
      sof2 = (b == 0); vld2 = 1; din2 = W'(b);
      step2();
    end
    sof2 = 0; vld2 = 0;
    step2();
    chk("w_empty", emp2, 0);
    chk("w_align", ae2, 0);
    rd2[62] = 1'b1;
    step2();
    rd2 = '0;
    chk("w_dout62", dout2[62*W +: W], 62);
    chk("w_vld62", dv2, NCH2'(1) << 62);
    // Partial row, then asynchronous reset in the middle of a cycle.
    for (int b = 0; b < 10; b++) begin
      vld2 = 1; din2 = W'(100 + b);
      step2();
    end
    vld2 = 0;
    #2 rst2 = 1'b1;
    #1;
    chk("w_rst_empty", emp2, ones2);
    chk("w_rst_full", ful2, 0);
    chk("w_rst_dout", dout2[62*W +: W], 0);
    @(posedge clk);
    #1 rst2 = 1'b0;
    vld2 = 1; din2 = 8'hAB;
    step2();
    vld2 = 0;
    step2();
    rd2[0] = 1'b1;
    step2();
    rd2 = '0;
    chk("w_ch0_after_rst", dout2[W-1:0], 8'hAB);
    chk("w_vld0_after_rst", dv2, NCH2'(1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
